xmul_share_arb: RTL and testbench



---
 rtl/xmul_arb_pkg.sv | 13 +
 rtl/xmul_rr_arb.sv | 72 +++++++
 rtl/xmul_share_arb.sv | 77 +++++++
 tb/tb_xmul_share_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xmul_arb_pkg.sv
// rtl/xmul_arb_pkg.sv - shared constants and tag type for the shared multiplier arbiter
package xmul_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = 2;
  localparam int MUL_LAT   = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/xmul_rr_arb.sv
// rtl/xmul_rr_arb.sv - one-hot grant arbiter; XMUL_ARB_FIXED_PRIO_EN selects fixed priority
module xmul_rr_arb
  import xmul_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gid
);

`ifdef XMUL_ARB_FIXED_PRIO_EN

  // Clock and reset are not needed without a pointer register.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Lowest valid index wins; scanning downward leaves the lowest one in place.
  always_comb begin
    grant = '0;
    gid   = '0;
    if (en && !rst) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (valid[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          gid      = ID_W'(i);
        end
      end
    end
  end

`else

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   idx;
  logic            found;

  // First valid requester at or after ptr wins, wrapping to 0.
  always_comb begin
    grant = '0;
    gid   = '0;
    idx   = '0;
    found = 1'b0;
    if (en && !rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = {1'b0, ptr} + (ID_W+1)'(i);
        if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
        if (!found && valid[idx[ID_W-1:0]]) begin
          found                   = 1'b1;
          grant[idx[ID_W-1:0]]    = 1'b1;
          gid                     = idx[ID_W-1:0];
        end
      end
    end
  end

  // Pointer moves to the slot after the winner; holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/xmul_share_arb.sv
// rtl/xmul_share_arb.sv - shares one pipelined signed 32x32 multiplier among requesters (XMUL_ARB_FIXED_PRIO_EN)
module xmul_share_arb
  import xmul_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_op_a,
  input  logic [N_REQ*32-1:0] req_op_b,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [63:0]        rsp_product,
  output logic               busy
);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gid;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_pipe [MUL_LAT];
  tag_t             tag      [MUL_LAT];

  xmul_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .valid (req_valid),
    .grant (grant),
    .gid   (gid)
  );

  assign req_ready = grant;

  // Operand mux: winner's operands, zeros when idle.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (|grant) begin
      mul_a = req_op_a[int'(gid)*32 +: 32];
      mul_b = req_op_b[int'(gid)*32 +: 32];
    end
  end

  // Multiplier: data-only pipeline, its output is qualified by the tag valid bit.
  always_ff @(posedge clk) begin
    mul_pipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  // Tag pipe tracks which requester owns each product in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{vld: |grant, id: gid};
      for (int i = 1; i < MUL_LAT; i++) tag[i] <= tag[i-1];
    end
  end

  // Response decode from the last tag stage.
  always_comb begin
    rsp_valid = '0;
    if (tag[MUL_LAT-1].vld) rsp_valid[tag[MUL_LAT-1].id] = 1'b1;
  end

  assign rsp_product = mul_pipe[MUL_LAT-1];

  // Busy while any tag stage holds an op.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | tag[i].vld;
  end

endmodule

// File: tb/tb_xmul_share_arb.sv
// tb/tb_xmul_share_arb.sv - self-checking bench for xmul_share_arb
module tb_xmul_share_arb;
  import xmul_arb_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_op_a = '0;
  logic [N*32-1:0] req_op_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [63:0]     rsp_product;
  logic            busy;

  xmul_share_arb #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op_a    (req_op_a),
    .req_op_b    (req_op_b),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] prod;
    int          due;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   ncyc    = 0;
  int   mptr    = 0;
  exp_t q[$];
  int   gnt_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int model_win(input logic [N-1:0] v, input logic e, input int p);
    if (!e) return -1;
`ifdef XMUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
`endif
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    int          w;
    exp_t        e;
    longint      sa;
    longint      sb;
    ncyc++;
    if (rst) begin
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      q.delete();
      mptr = 0;
    end else begin
      chk("busy", 64'(busy), 64'(q.size() != 0));
      if (q.size() != 0 && q[0].due == ncyc) begin
        chk("rsp_valid", 64'(rsp_valid), onehot(q[0].id));
        chk("rsp_product", rsp_product, q[0].prod);
        void'(q.pop_front());
      end else begin
        chk("rsp_idle", 64'(rsp_valid), 64'd0);
      end
      w = model_win(req_valid, en, mptr);
      chk("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : onehot(w));
      if (w >= 0) begin
        sa     = $signed(req_op_a[32*w +: 32]);
        sb     = $signed(req_op_b[32*w +: 32]);
        e.id   = w;
        e.prod = 64'(sa * sb);
        e.due  = ncyc + MUL_LAT;
        q.push_back(e);
        gnt_log.push_back(w);
        mptr = (w == N - 1) ? 0 : w + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[6];
  int   exp_ord[8];
  int   exp4[3];

  initial begin
    tbl[0] = '{0, 32'd3,          32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[1] = '{2, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    tbl[2] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    tbl[3] = '{3, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    tbl[4] = '{0, 32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000};
    tbl[5] = '{3, 32'd0,          32'h1234_5678, 64'h0};
`ifdef XMUL_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp4    = '{1, 1, 1};
`else
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp4    = '{1, 3, 1};
`endif

    #1;
    chk("reset_ready0", 64'(req_ready), 64'd0);
    chk("reset_busy0", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Single-op vectors, product checked against table constants
    foreach (tbl[k]) begin
      req_op_a[32*tbl[k].id +: 32] = tbl[k].a;
      req_op_b[32*tbl[k].id +: 32] = tbl[k].b;
      req_valid = N'(onehot(tbl[k].id));
      @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (3) @(negedge clk);
      chk($sformatf("tbl%0d_valid", k), 64'(rsp_valid), onehot(tbl[k].id));
      chk($sformatf("tbl%0d_product", k), rsp_product, tbl[k].prod);
      step();
    end

    // All four requesters valid for 8 cycles from rr_ptr=0
    do_reset();
    gnt_log.delete();
    req_valid = '1;
    repeat (8) begin
      for (int i = 0; i < N; i++) begin
        req_op_a[32*i +: 32] = $urandom;
        req_op_b[32*i +: 32] = $urandom;
      end
      step();
    end
    req_valid = '0;
    repeat (4) step();
    chk("rr_count", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      chk($sformatf("rr_order%0d", i), 64'(gnt_log[i]), 64'(exp_ord[i]));

    // Pointer at 2, requesters 1 and 3, then en drops
    do_reset();
    gnt_log.delete();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    step();
    step();
    en = 1'b0;
    step();
    chk("en_off_busy_l2", 64'(busy), 64'd1);
    req_valid = '0;
    en = 1'b1;
    step();
    chk("en_off_busy_l3", 64'(busy), 64'd1);
    step();
    chk("en_off_busy_l4", 64'(busy), 64'd0);
    chk("p4_count", 64'(gnt_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < gnt_log.size(); i++)
      chk($sformatf("p4_order%0d", i), 64'(gnt_log[i]), 64'(exp4[i]));
    step();

    // Asynchronous reset with three ops in flight
    req_valid = '1;
    repeat (3) step();
    req_valid = '0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_rsp", 64'(|rsp_valid), 64'd1);
    req_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp", 64'(rsp_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    step();
    step();
    rst = 1'b0;
    req_valid = '0;
    repeat (6) step();

`ifdef XMUL_ARB_FIXED_PRIO_EN
    // Requesters 0 and 1 continuously valid: 0 always wins
    gnt_log.delete();
    req_valid = 4'b0011;
    repeat (6) step();
    req_valid = '0;
    repeat (4) step();
    chk("fixed_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < gnt_log.size(); i++)
      chk($sformatf("fixed_grant%0d", i), 64'(gnt_log[i]), 64'd0);
`endif

    repeat (5) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
